// File: rtl/pdp8_intctl.sv
// PDP-8 interrupt controller: ION/IOF state with one-instruction ION delay,
// device-00 IOTs (SKON, ION, IOF, SRQ) and fixed-priority interrupt grant.
module pdp8_intctl #(
    parameter int NDEV = 4,
    parameter int SRCW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iot,
    input  logic [3:0]      state,
    input  logic [11:0]     mb,
    input  logic [5:0]      io_select,
    input  logic [NDEV-1:0] irq_in,
    input  logic            instr_end,
    input  logic            int_ack,
    output logic            io_selected,
    output logic            io_skip,
    output logic            int_req,
    output logic [SRCW-1:0] int_src,
    output logic            ion
);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        PEND  = 2'd1,
        ON    = 2'd2,
        GRANT = 2'd3
    } st_t;

    localparam logic [2:0] FN_SKON = 3'd0;
    localparam logic [2:0] FN_ION  = 3'd1;
    localparam logic [2:0] FN_IOF  = 3'd2;
    localparam logic [2:0] FN_SRQ  = 3'd3;

    st_t             st, st_nxt;
    logic [SRCW-1:0] src_q, src_nxt;
    logic [SRCW-1:0] enc;
    logic            dev0;
    logic            any_irq;
    logic            iot_off;
    logic [2:0]      fn;
    logic            unused_mb;

    assign fn        = mb[2:0];
    assign unused_mb = ^mb[11:3];
    assign any_irq   = |irq_in;
    assign dev0      = iot && (state == 4'd1) && (io_select == 6'o00);
    assign iot_off   = dev0 && ((fn == FN_SKON) || (fn == FN_IOF));

    assign io_selected = dev0;
    assign int_req     = (st == GRANT);
    assign ion         = (st == ON);
    assign int_src     = src_q;

    // Lowest set index wins.
    always_comb begin
        enc = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (irq_in[i]) enc = SRCW'(i);
        end
    end

    always_comb begin
        io_skip = 1'b0;
        if (dev0) begin
            case (fn)
                FN_SKON: io_skip = (st == ON) || (st == PEND);
                FN_SRQ:  io_skip = any_irq;
                default: io_skip = 1'b0;
            endcase
        end
    end

    // IOT effects take precedence over the instruction boundary.
    always_comb begin
        st_nxt  = st;
        src_nxt = src_q;
        unique case (st)
            OFF: begin
                if (dev0 && (fn == FN_ION)) st_nxt = PEND;
            end
            PEND: begin
                if (iot_off)        st_nxt = OFF;
                else if (instr_end) st_nxt = ON;
            end
            ON: begin
                if (iot_off) begin
                    st_nxt = OFF;
                end else if (instr_end && any_irq) begin
                    st_nxt  = GRANT;
                    src_nxt = enc;
                end
            end
            GRANT: begin
                if (int_ack) st_nxt = OFF;
            end
            default: st_nxt = OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= OFF;
            src_q <= '0;
        end else begin
            st    <= st_nxt;
            src_q <= src_nxt;
        end
    end

endmodule

// File: tb/tb_pdp8_intctl.sv
// Directed vector bench for pdp8_intctl.
module tb_pdp8_intctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        iot;
    logic [3:0]  state;
    logic [11:0] mb;
    logic [5:0]  io_select;
    logic [3:0]  irq_in;
    logic        instr_end;
    logic        int_ack;
    logic        io_selected;
    logic        io_skip;
    logic        int_req;
    logic [1:0]  int_src;
    logic        ion;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    pdp8_intctl #(.NDEV(4), .SRCW(2)) dut (
        .clk(clk),
        .reset(reset),
        .iot(iot),
        .state(state),
        .mb(mb),
        .io_select(io_select),
        .irq_in(irq_in),
        .instr_end(instr_end),
        .int_ack(int_ack),
        .io_selected(io_selected),
        .io_skip(io_skip),
        .int_req(int_req),
        .int_src(int_src),
        .ion(ion)
    );

    typedef struct {
        string       name;
        logic        iot;
        logic [3:0]  st;
        logic [11:0] mb;
        logic [5:0]  sel;
        logic [3:0]  irq;
        logic        ie;
        logic        ack;
        logic        e_sel;
        logic        e_skip;
        logic        e_req;
        logic [1:0]  e_src;
        logic        e_ion;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(string nm, logic i, logic [3:0] s,
                               logic [11:0] m, logic [5:0] d,
                               logic [3:0] q, logic ie, logic ak,
                               logic es, logic ek, logic er,
                               logic [1:0] ec, logic en);
        vec_t r;
        r.name = nm; r.iot = i; r.st = s; r.mb = m; r.sel = d;
        r.irq = q; r.ie = ie; r.ack = ak;
        r.e_sel = es; r.e_skip = ek; r.e_req = er;
        r.e_src = ec; r.e_ion = en;
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(logic i, logic [3:0] s, logic [11:0] m,
                         logic [5:0] d, logic [3:0] q, logic ie, logic ak);
        iot = i; state = s; mb = m; io_select = d;
        irq_in = q; instr_end = ie; int_ack = ak;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(0, 4'd0, 12'o0, 6'o0, 4'b0, 0, 0);

        //        name        iot st  mb      sel   irq     ie ak sel skp req src ion
        vq.push_back(v("ion",      1, 1, 12'o6001, 6'o00, 4'b0100, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("pend_ie",  0, 0, 12'o0000, 6'o00, 4'b0100, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(v("grant2",   0, 0, 12'o0000, 6'o00, 4'b0100, 1, 0, 0, 0, 1, 2, 0));
        vq.push_back(v("irq_drop", 0, 0, 12'o0000, 6'o00, 4'b0000, 0, 0, 0, 0, 1, 2, 0));
        vq.push_back(v("ack",      0, 0, 12'o0000, 6'o00, 4'b0000, 0, 1, 0, 0, 0, 0, 0));
        vq.push_back(v("skon_off", 1, 1, 12'o6000, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("ion2",     1, 1, 12'o6001, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("skon_pnd", 1, 1, 12'o6000, 6'o00, 4'b0000, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(v("ion3",     1, 1, 12'o6001, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("ion_pnd",  1, 1, 12'o6001, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("pend_ie2", 0, 0, 12'o0000, 6'o00, 4'b0000, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(v("on_noirq", 0, 0, 12'o0000, 6'o00, 4'b0000, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(v("on_ack",   0, 0, 12'o0000, 6'o00, 4'b0000, 0, 1, 0, 0, 0, 0, 1));
        vq.push_back(v("grant1",   0, 0, 12'o0000, 6'o00, 4'b1010, 1, 0, 0, 0, 1, 1, 0));
        vq.push_back(v("iot_grnt", 1, 1, 12'o6002, 6'o00, 4'b1010, 0, 0, 1, 0, 1, 1, 0));
        vq.push_back(v("ack_iot",  1, 1, 12'o6002, 6'o00, 4'b1010, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(v("ion4",     1, 1, 12'o6001, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("pend_ie3", 0, 0, 12'o0000, 6'o00, 4'b0000, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(v("skon_on",  1, 1, 12'o6000, 6'o00, 4'b0000, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(v("skon_rep", 1, 1, 12'o6000, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("srq_0",    1, 1, 12'o6003, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("srq_1",    1, 1, 12'o6003, 6'o00, 4'b0001, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(v("fn5",      1, 1, 12'o6005, 6'o00, 4'b0001, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("ion5",     1, 1, 12'o6001, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("iof_ie",   1, 1, 12'o6002, 6'o00, 4'b0000, 1, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("ion_ie",   1, 1, 12'o6001, 6'o00, 4'b1111, 1, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("pend_ie4", 0, 0, 12'o0000, 6'o00, 4'b1111, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(v("grant0",   0, 0, 12'o0000, 6'o00, 4'b1111, 1, 0, 0, 0, 1, 0, 0));
        vq.push_back(v("ack2",     0, 0, 12'o0000, 6'o00, 4'b1111, 0, 1, 0, 0, 0, 0, 0));
        vq.push_back(v("ie_off",   0, 0, 12'o0000, 6'o00, 4'b1111, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(v("dev13",    1, 1, 12'o6131, 6'o13, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v("ion_f2",   1, 2, 12'o6001, 6'o00, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v("ion_noiot",0, 1, 12'o6001, 6'o00, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v("ion6",     1, 1, 12'o6001, 6'o00, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v("pend_ie5", 0, 0, 12'o0000, 6'o00, 4'b0000, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(v("iof_on",   1, 1, 12'o6002, 6'o00, 4'b0100, 1, 0, 1, 0, 0, 0, 0));

        #1;
        chk("rst_req", int_req, 0);
        chk("rst_src", int_src, 0);
        chk("rst_ion", ion, 0);
        chk("rst_sel", io_selected, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].iot, vq[i].st, vq[i].mb, vq[i].sel,
                  vq[i].irq, vq[i].ie, vq[i].ack);
            #1;
            chk({vq[i].name, ".sel"}, io_selected, vq[i].e_sel);
            chk({vq[i].name, ".skip"}, io_skip, vq[i].e_skip);
            @(posedge clk);
            #1;
            chk({vq[i].name, ".req"}, int_req, vq[i].e_req);
            chk({vq[i].name, ".ion"}, ion, vq[i].e_ion);
            if (vq[i].e_req)
                chk({vq[i].name, ".src"}, int_src, vq[i].e_src);
        end

        // Asynchronous reset while a grant is outstanding.
        @(negedge clk);
        drive(1, 4'd1, 12'o6001, 6'o00, 4'b1000, 0, 0);
        @(negedge clk);
        drive(0, 4'd0, 12'o0, 6'o00, 4'b1000, 1, 0);
        @(negedge clk);
        drive(0, 4'd0, 12'o0, 6'o00, 4'b1000, 1, 0);
        @(posedge clk);
        #1;
        chk("ar_pre_req", int_req, 1);
        chk("ar_pre_src", int_src, 3);
        drive(0, 4'd0, 12'o0, 6'o00, 4'b1000, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_req", int_req, 0);
        chk("ar_ion", ion, 0);
        chk("ar_src", int_src, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 4'd0, 12'o0, 6'o00, 4'b1000, 1, 0);
        @(posedge clk);
        #1;
        chk("ar_post_req", int_req, 0);
        chk("ar_post_ion", ion, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
